// File: rtl/issue_dispatch_queue.sv
// issue_dispatch_queue: instruction buffer and single-issue dispatch stage.
// Fetched instructions enter a DEPTH-entry circular FIFO; the head entry is
// moved into a one-deep stage register, decoded, and dispatched to the ROB
// plus (optionally) the reservation station or load/store buffer once every
// sink it needs has room.
//
// Ports:
//   clk_in, rst_in        clock, synchronous active-high reset
//   rdy_in                global enable; low freezes all state and dispatch
//   clear                 flush: empties queue and stage, discards a push
//   inst_in/inst_valid/inst_addr  fetch push interface; fetch_ready = room
//   rob_full/rs_full/lsb_full     sink back-pressure
//   rob_tail_id           ROB tag that the next dispatched entry receives
//   dispatch_fire         staged instruction leaves toward the ROB this cycle
//   to_rs/to_lsb          fire qualified for the RS / LSB
//   d_*                   decoded view of the stage register
//   count                 queue occupancy (stage register not included)
module issue_dispatch_queue #(
  parameter int unsigned DEPTH        = 32,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned ROB_ID_WIDTH = 5
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      clear,
  input  logic [31:0]               inst_in,
  input  logic                      inst_valid,
  input  logic [ADDR_WIDTH-1:0]     inst_addr,
  output logic                      fetch_ready,
  input  logic                      rob_full,
  input  logic                      rs_full,
  input  logic                      lsb_full,
  input  logic [ROB_ID_WIDTH-1:0]   rob_tail_id,
  output logic                      dispatch_fire,
  output logic                      to_rs,
  output logic                      to_lsb,
  output logic [6:0]                d_opcode,
  output logic [2:0]                d_funct3,
  output logic                      d_funct7b5,
  output logic [4:0]                d_rd,
  output logic [4:0]                d_rs1,
  output logic [4:0]                d_rs2,
  output logic [31:0]               d_imm,
  output logic [ADDR_WIDTH-1:0]     d_pc,
  output logic [31:0]               d_rob_value,
  output logic [ROB_ID_WIDTH-1:0]   d_rob_id,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [1:0] {
    CLS_DROP,
    CLS_ALU,
    CLS_MEM,
    CLS_ROB
  } cls_e;

  typedef enum logic [2:0] {
    FMT_X,
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } fmt_e;

  logic [31:0]           q_inst [DEPTH];
  logic [ADDR_WIDTH-1:0] q_pc   [DEPTH];
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;

  logic                  stage_valid;
  logic [31:0]           stage_inst;
  logic [ADDR_WIDTH-1:0] stage_pc;

  cls_e                  cls;
  fmt_e                  fmt;
  logic                  active;
  logic                  push;
  logic                  load;
  logic                  stage_leave;
  logic                  sinks_ok;

  // Classification and immediate format of the staged opcode.
  always_comb begin
    cls = CLS_DROP;
    fmt = FMT_X;
    case (stage_inst[6:0])
      OPC_OP:     begin cls = CLS_ALU; fmt = FMT_R; end
      OPC_OPIMM:  begin cls = CLS_ALU; fmt = FMT_I; end
      OPC_BRANCH: begin cls = CLS_ALU; fmt = FMT_B; end
      OPC_JAL:    begin cls = CLS_ALU; fmt = FMT_J; end
      OPC_JALR:   begin cls = CLS_ALU; fmt = FMT_I; end
      OPC_LOAD:   begin cls = CLS_MEM; fmt = FMT_I; end
      OPC_STORE:  begin cls = CLS_MEM; fmt = FMT_S; end
      OPC_LUI:    begin cls = CLS_ROB; fmt = FMT_U; end
      OPC_AUIPC:  begin cls = CLS_ROB; fmt = FMT_U; end
      default:    begin cls = CLS_DROP; fmt = FMT_X; end
    endcase
  end

  // Handshake: a frozen or flushing cycle neither pushes, loads nor fires.
  always_comb begin
    active        = rdy_in && !clear;
    fetch_ready   = (count != CNT_W'(DEPTH));
    push          = active && inst_valid && fetch_ready;
    sinks_ok      = !rob_full
                    && !((cls == CLS_ALU) && rs_full)
                    && !((cls == CLS_MEM) && lsb_full);
    dispatch_fire = active && stage_valid && (cls != CLS_DROP) && sinks_ok;
    // Unknown opcodes retire from the stage without consuming any sink.
    stage_leave   = dispatch_fire || (active && stage_valid && (cls == CLS_DROP));
    load          = active && (count != '0) && (!stage_valid || stage_leave);
    to_rs         = dispatch_fire && (cls == CLS_ALU);
    to_lsb        = dispatch_fire && (cls == CLS_MEM);
  end

  // Queue payload storage; no reset needed, validity is tracked by count.
  always_ff @(posedge clk_in) begin
    if (push) begin
      q_inst[tail] <= inst_in;
      q_pc[tail]   <= inst_addr;
    end
  end

  // Pointers, occupancy and stage register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      stage_valid <= 1'b0;
      stage_inst  <= '0;
      stage_pc    <= '0;
    end else if (rdy_in) begin
      if (clear) begin
        head        <= '0;
        tail        <= '0;
        count       <= '0;
        stage_valid <= 1'b0;
        stage_inst  <= '0;
        stage_pc    <= '0;
      end else begin
        if (push) begin
          tail <= tail + PTR_W'(1);
        end
        if (load) begin
          head        <= head + PTR_W'(1);
          stage_valid <= 1'b1;
          stage_inst  <= q_inst[head];
          stage_pc    <= q_pc[head];
        end else if (stage_leave) begin
          stage_valid <= 1'b0;
        end
        case ({push, load})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Field decode and sign-extended immediate of the stage register.
  always_comb begin
    d_opcode   = stage_inst[6:0];
    d_funct3   = stage_inst[14:12];
    d_funct7b5 = stage_inst[30];
    d_pc       = stage_pc;
    d_rob_id   = rob_tail_id;

    d_rd  = ((fmt == FMT_S) || (fmt == FMT_B)) ? 5'd0 : stage_inst[11:7];
    d_rs1 = ((fmt == FMT_U) || (fmt == FMT_J)) ? 5'd0 : stage_inst[19:15];
    d_rs2 = ((fmt == FMT_R) || (fmt == FMT_S) || (fmt == FMT_B))
            ? stage_inst[24:20] : 5'd0;

    d_imm = '0;
    case (fmt)
      FMT_I: d_imm = {{20{stage_inst[31]}}, stage_inst[31:20]};
      FMT_S: d_imm = {{20{stage_inst[31]}}, stage_inst[31:25], stage_inst[11:7]};
      FMT_B: d_imm = {{19{stage_inst[31]}}, stage_inst[31], stage_inst[7],
                      stage_inst[30:25], stage_inst[11:8], 1'b0};
      FMT_U: d_imm = {stage_inst[31:12], 12'd0};
      FMT_J: d_imm = {{11{stage_inst[31]}}, stage_inst[31], stage_inst[19:12],
                      stage_inst[20], stage_inst[30:21], 1'b0};
      default: d_imm = '0;
    endcase

    // LUI/AUIPC results are known at dispatch and go straight into the ROB.
    d_rob_value = '0;
    if (stage_inst[6:0] == OPC_LUI) begin
      d_rob_value = d_imm;
    end else if (stage_inst[6:0] == OPC_AUIPC) begin
      d_rob_value = 32'(stage_pc) + d_imm;
    end
  end

endmodule

// File: tb/tb_issue_dispatch_queue.sv
// Directed bench for issue_dispatch_queue (DEPTH = 8).
module tb_issue_dispatch_queue;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 32;
  localparam int unsigned RW    = 5;

  localparam logic [31:0] I_ADDI5  = 32'h0050_0093; // addi x1,x0,5
  localparam logic [31:0] I_ADDIM1 = 32'hFFF0_8093; // addi x1,x1,-1
  localparam logic [31:0] I_AUIPC  = 32'h1234_5197; // auipc x3,0x12345
  localparam logic [31:0] I_LUI    = 32'hABCD_E2B7; // lui x5,0xABCDE
  localparam logic [31:0] I_ADD    = 32'h0010_8133; // add x2,x1,x1
  localparam logic [31:0] I_SW     = 32'h0020_A423; // sw x2,8(x1)
  localparam logic [31:0] I_FENCE  = 32'h0000_000F;

  logic            clk_in = 1'b0;
  logic            rst_in;
  logic            rdy_in;
  logic            clear;
  logic [31:0]     inst_in;
  logic            inst_valid;
  logic [AW-1:0]   inst_addr;
  logic            fetch_ready;
  logic            rob_full;
  logic            rs_full;
  logic            lsb_full;
  logic [RW-1:0]   rob_tail_id;
  logic            dispatch_fire;
  logic            to_rs;
  logic            to_lsb;
  logic [6:0]      d_opcode;
  logic [2:0]      d_funct3;
  logic            d_funct7b5;
  logic [4:0]      d_rd;
  logic [4:0]      d_rs1;
  logic [4:0]      d_rs2;
  logic [31:0]     d_imm;
  logic [AW-1:0]   d_pc;
  logic [31:0]     d_rob_value;
  logic [RW-1:0]   d_rob_id;
  logic [3:0]      count;

  int n_assert = 0;
  int n_fail   = 0;

  issue_dispatch_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .ROB_ID_WIDTH(RW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .inst_in(inst_in), .inst_valid(inst_valid), .inst_addr(inst_addr),
    .fetch_ready(fetch_ready), .rob_full(rob_full), .rs_full(rs_full),
    .lsb_full(lsb_full), .rob_tail_id(rob_tail_id),
    .dispatch_fire(dispatch_fire), .to_rs(to_rs), .to_lsb(to_lsb),
    .d_opcode(d_opcode), .d_funct3(d_funct3), .d_funct7b5(d_funct7b5),
    .d_rd(d_rd), .d_rs1(d_rs1), .d_rs2(d_rs2), .d_imm(d_imm), .d_pc(d_pc),
    .d_rob_value(d_rob_value), .d_rob_id(d_rob_id), .count(count)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs are then changed 1 time unit after it.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [AW-1:0] pc);
    inst_valid = v;
    inst_in    = ins;
    inst_addr  = pc;
  endtask

  initial begin
    logic [AW-1:0] exp_pc [10];

    rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0;
    rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0;
    rob_tail_id = 5'd7;
    drive(1'b0, '0, '0);
    step();
    step();
    rst_in = 1'b0;
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_fetch_ready", 64'(fetch_ready), 64'd1);
    chk("rst_fire", 64'(dispatch_fire), 64'd0);
    chk("rst_to_rs", 64'(to_rs), 64'd0);
    chk("rst_to_lsb", 64'(to_lsb), 64'd0);
    chk("rst_d_imm", 64'(d_imm), 64'd0);
    chk("rst_d_rd", 64'(d_rd), 64'd0);
    chk("rst_d_rob_value", 64'(d_rob_value), 64'd0);

    // ADDI x1,x0,5 at pc 0: fires two edges after the push.
    drive(1'b1, I_ADDI5, 32'h0);
    step();
    drive(1'b0, '0, '0);
    chk("addi_count1", 64'(count), 64'd1);
    chk("addi_nofire_early", 64'(dispatch_fire), 64'd0);
    step();
    chk("addi_fire", 64'(dispatch_fire), 64'd1);
    chk("addi_to_rs", 64'(to_rs), 64'd1);
    chk("addi_to_lsb", 64'(to_lsb), 64'd0);
    chk("addi_imm", 64'(d_imm), 64'd5);
    chk("addi_rd", 64'(d_rd), 64'd1);
    chk("addi_rob_id", 64'(d_rob_id), 64'd7);
    chk("addi_count0", 64'(count), 64'd0);
    step();
    chk("addi_gone", 64'(dispatch_fire), 64'd0);

    // Negative I-immediate sign extension.
    drive(1'b1, I_ADDIM1, 32'h40);
    step();
    drive(1'b0, '0, '0);
    step();
    chk("neg_imm", 64'(d_imm), 64'hFFFF_FFFF);
    chk("neg_rs1", 64'(d_rs1), 64'd1);
    step();

    // AUIPC and LUI are ROB-only.
    drive(1'b1, I_AUIPC, 32'h100);
    step();
    drive(1'b0, '0, '0);
    step();
    chk("auipc_fire", 64'(dispatch_fire), 64'd1);
    chk("auipc_to_rs", 64'(to_rs), 64'd0);
    chk("auipc_to_lsb", 64'(to_lsb), 64'd0);
    chk("auipc_rob_value", 64'(d_rob_value), 64'h1234_5100);
    chk("auipc_rd", 64'(d_rd), 64'd3);
    step();
    drive(1'b1, I_LUI, 32'h104);
    step();
    drive(1'b0, '0, '0);
    step();
    chk("lui_fire", 64'(dispatch_fire), 64'd1);
    chk("lui_to_rs", 64'(to_rs), 64'd0);
    chk("lui_rob_value", 64'(d_rob_value), 64'hABCD_E000);
    step();

    // SW blocked by lsb_full, then released.
    drive(1'b1, I_SW, 32'h200);
    step();
    drive(1'b0, '0, '0);
    lsb_full = 1'b1;
    step();
    chk("sw_blocked", 64'(dispatch_fire), 64'd0);
    chk("sw_blocked_lsb", 64'(to_lsb), 64'd0);
    step();
    chk("sw_hold_fire", 64'(dispatch_fire), 64'd0);
    chk("sw_hold_pc", 64'(d_pc), 64'h200);
    lsb_full = 1'b0;
    #1;
    chk("sw_fire", 64'(dispatch_fire), 64'd1);
    chk("sw_to_lsb", 64'(to_lsb), 64'd1);
    chk("sw_imm", 64'(d_imm), 64'd8);
    chk("sw_rd", 64'(d_rd), 64'd0);
    chk("sw_rs2", 64'(d_rs2), 64'd2);
    step();

    // ADD is not affected by lsb_full.
    lsb_full = 1'b1;
    drive(1'b1, I_ADD, 32'h204);
    step();
    drive(1'b0, '0, '0);
    step();
    chk("add_fire", 64'(dispatch_fire), 64'd1);
    chk("add_to_rs", 64'(to_rs), 64'd1);
    chk("add_rs2", 64'(d_rs2), 64'd1);
    chk("add_rd", 64'(d_rd), 64'd2);
    step();
    lsb_full = 1'b0;

    // FENCE is dropped in one cycle even with rob_full; ADDI behind it waits.
    rob_full = 1'b1;
    drive(1'b1, I_FENCE, 32'h300);
    step();
    drive(1'b1, I_ADDI5, 32'h304);
    step();
    drive(1'b0, '0, '0);
    chk("fence_nofire", 64'(dispatch_fire), 64'd0);
    chk("fence_count", 64'(count), 64'd1);
    step();
    chk("fence_dropped_pc", 64'(d_pc), 64'h304);
    chk("fence_dropped_count", 64'(count), 64'd0);
    chk("robfull_nofire", 64'(dispatch_fire), 64'd0);
    rob_full = 1'b0;
    #1;
    chk("after_fence_fire", 64'(dispatch_fire), 64'd1);
    step();

    // Back-pressure: DEPTH+1 ALU ops fill stage + queue.
    rs_full = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, I_ADDI5, 32'h1000 + 32'(4 * i));
      step();
    end
    chk("bp_count_full", 64'(count), 64'd8);
    chk("bp_fetch_ready", 64'(fetch_ready), 64'd0);
    chk("bp_nofire", 64'(dispatch_fire), 64'd0);
    drive(1'b1, I_ADDI5, 32'h1024);
    step();
    drive(1'b0, '0, '0);
    chk("bp_count_sat", 64'(count), 64'd8);
    rs_full = 1'b0;
    #1;
    for (int i = 0; i < 9; i++) exp_pc[i] = 32'h1000 + 32'(4 * i);
    exp_pc[9] = 32'h2000;
    // Drain in order; push during a load at count = DEPTH-1 keeps count.
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("drain_fire_%0d", i), 64'(dispatch_fire), 64'd1);
      chk($sformatf("drain_pc_%0d", i), 64'(d_pc), 64'(exp_pc[i]));
      if (i == 1) drive(1'b1, I_ADDI5, 32'h2000);
      step();
      drive(1'b0, '0, '0);
      if (i == 1) chk("simul_push_load_count", 64'(count), 64'd7);
      if (i == 8) chk("drain_count0", 64'(count), 64'd0);
    end
    chk("drain_done", 64'(dispatch_fire), 64'd0);

    // Clear with a concurrent push, queue half full.
    rs_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, I_ADDI5, 32'h3000 + 32'(4 * i));
      step();
    end
    chk("clr_pre_count", 64'(count), 64'd4);
    rs_full = 1'b0;
    clear = 1'b1;
    drive(1'b1, I_ADDI5, 32'h3100);
    #1;
    chk("clr_fire_gated", 64'(dispatch_fire), 64'd0);
    step();
    clear = 1'b0;
    drive(1'b0, '0, '0);
    #1;
    chk("clr_count", 64'(count), 64'd0);
    chk("clr_nofire", 64'(dispatch_fire), 64'd0);
    chk("clr_fetch_ready", 64'(fetch_ready), 64'd1);
    step();
    step();
    chk("clr_push_discarded", 64'(dispatch_fire), 64'd0);
    chk("clr_count_stays", 64'(count), 64'd0);

    // rdy_in low for 3 cycles freezes everything.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, I_ADDI5, 32'h4000 + 32'(4 * i));
      step();
    end
    chk("rdy_pre_pc", 64'(d_pc), 64'h4004);
    chk("rdy_pre_count", 64'(count), 64'd1);
    rdy_in = 1'b0;
    drive(1'b1, I_ADDI5, 32'h400C);
    #1;
    chk("rdy_nofire", 64'(dispatch_fire), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("frz_count_%0d", i), 64'(count), 64'd1);
      chk($sformatf("frz_pc_%0d", i), 64'(d_pc), 64'h4004);
      chk($sformatf("frz_fire_%0d", i), 64'(dispatch_fire), 64'd0);
    end
    rdy_in = 1'b1;
    drive(1'b0, '0, '0);
    #1;
    chk("resume_fire", 64'(dispatch_fire), 64'd1);
    chk("resume_pc", 64'(d_pc), 64'h4004);
    step();
    chk("resume_next_pc", 64'(d_pc), 64'h4008);
    chk("resume_next_fire", 64'(dispatch_fire), 64'd1);
    step();
    chk("resume_empty_fire", 64'(dispatch_fire), 64'd0);
    chk("resume_empty_count", 64'(count), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
